imem_loader: RTL and testbench

Byte-stream loader that fills the instruction RAM of `single_cycle_cpu` and holds the core in reset until the program is in place. It is the writer for the memory the CPU fetches from, and replaces `$readmemh` preloading on hardware. It parses a framed byte stream, packs bytes big-endian into 32-bit words, and writes them to consecutive word addresses from 0. After the frame checksum passes, it releases the CPU.

---
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the CPU instruction RAM.
// Packs bytes big-endian into words, writes them from address 0, and releases the CPU once the checksum matches.
module imem_loader #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [7:0]  HEADER    = 8'hA5;
    localparam logic [31:0] DEPTH_LIM = 32'(MEM_DEPTH);

    state_t            state_q, state_d;
    logic [8:0]        wordCnt_q, nWords_q;
    logic [1:0]        byteCnt_q;
    logic [23:0]       asm_q;
    logic [7:0]        xor_q;
    logic              rxReady_q, memWe_q, cpuReset_q, busy_q, done_q, error_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [31:0]       memWdata_q;

    logic       accept;
    logic [8:0] lenN;
    logic       lenTooBig, lastWord, wordEnd;

    // A start pulse withdraws rx_ready so a byte offered alongside it is never consumed.
    assign rx_ready  = rxReady_q & ~start;
    assign accept    = rx_valid & rx_ready;
    assign lenN      = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
    assign lenTooBig = {23'd0, lenN} > DEPTH_LIM;
    assign lastWord  = (wordCnt_q == nWords_q - 9'd1);
    assign wordEnd   = (byteCnt_q == 2'd3);

    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign cpu_reset = cpuReset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = HDR;
        end else if (accept) begin
            case (state_q)
                HDR:     if (rx_data == HEADER) state_d = LEN;
                LEN:     state_d = lenTooBig ? ERR : DATA;
                DATA:    if (wordEnd && lastWord) state_d = CSUM;
                CSUM:    state_d = (rx_data == xor_q) ? DONE : ERR;
                default: state_d = state_q;
            endcase
        end
    end

    // Status outputs are registered from the next state so they change together with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wordCnt_q  <= '0;
            nWords_q   <= '0;
            byteCnt_q  <= '0;
            asm_q      <= '0;
            xor_q      <= '0;
            rxReady_q  <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            cpuReset_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rxReady_q  <= state_d inside {HDR, LEN, DATA, CSUM};
            busy_q     <= state_d inside {HDR, LEN, DATA, CSUM};
            cpuReset_q <= (state_d != DONE);
            done_q     <= (state_d == DONE);
            error_q    <= (state_d == ERR);
            memWe_q    <= 1'b0;
            if (start) begin
                wordCnt_q <= '0;
            end else if (accept) begin
                if (state_q == LEN) begin
                    nWords_q  <= lenN;
                    wordCnt_q <= '0;
                    byteCnt_q <= '0;
                    xor_q     <= '0;
                end else if (state_q == DATA) begin
                    asm_q     <= {asm_q[15:0], rx_data};
                    xor_q     <= xor_q ^ rx_data;
                    byteCnt_q <= byteCnt_q + 2'd1;
                    if (wordEnd) begin
                        memWe_q    <= 1'b1;
                        memAddr_q  <= ADDR_W'(wordCnt_q);
                        memWdata_q <= {asm_q, rx_data};
                        wordCnt_q  <= wordCnt_q + 9'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a frame-level reference model is compared every cycle,
// and literal expectations pin the nominal, failure, abort, boundary and reset scenarios.
module tb_imem_loader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef logic [7:0] bytes_t[$];

    logic          clk = 1'b0;
    logic          reset;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready, mem_we, cpu_reset, busy, done, error;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    int checksTotal  = 0;
    int checksPassed = 0;
    int weCount      = 0;
    logic [31:0] ram [DEPTH];

    imem_loader #(.MEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act === exp) checksPassed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: tracks position within the frame and derives writes and status arithmetically.
    bit          mActive = 0, mDone = 0, mErr = 0, mWe = 0;
    int          mPos = 0, mN = 0, k;
    logic [7:0]  mX = 8'h00;
    logic [31:0] mWord = 32'h0, mData = 32'h0;
    logic [AW-1:0] mAddr = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mActive = 0; mDone = 0; mErr = 0; mWe = 0; mPos = 0;
        end else begin
            mWe = 0;
            if (start) begin
                mActive = 1; mPos = 0; mDone = 0; mErr = 0;
            end else if (mActive && rx_valid) begin
                if (mPos == 0) begin
                    if (rx_data == 8'hA5) mPos = 1;
                end else if (mPos == 1) begin
                    mN = (rx_data == 8'h00) ? 256 : int'(rx_data);
                    if (mN > DEPTH) begin
                        mActive = 0; mErr = 1;
                    end else begin
                        mPos = 2; mX = 8'h00; mWord = 32'h0;
                    end
                end else if (mPos < 2 + 4 * mN) begin
                    k = mPos - 2;
                    mWord = {mWord[23:0], rx_data};
                    mX = mX ^ rx_data;
                    if (k % 4 == 3) begin
                        mWe = 1; mAddr = AW'(k / 4); mData = mWord;
                    end
                    mPos++;
                end else begin
                    mActive = 0;
                    if (rx_data == mX) mDone = 1;
                    else mErr = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("rx_ready", 32'(rx_ready), 32'(mActive && !start));
        check("busy", 32'(busy), 32'(mActive));
        check("done", 32'(done), 32'(mDone));
        check("error", 32'(error), 32'(mErr));
        check("cpu_reset", 32'(cpu_reset), 32'(!mDone));
        check("mem_we", 32'(mem_we), 32'(mWe));
        if (mWe) begin
            check("mem_addr", 32'(mem_addr), 32'(mAddr));
            check("mem_wdata", mem_wdata, mData);
        end
        if (mem_we) begin
            ram[mem_addr] = mem_wdata;
            weCount++;
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        rx_valid = 1'b1;
        rx_data = b;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("byte_accept_timeout", 32'(acc), 32'd1);
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input bytes_t f, input int gap);
        foreach (f[i]) begin
            sendByte(f[i]);
            if (gap > 0) idleCycles(gap);
        end
    endtask

    task automatic pulseStart(input logic offer, input logic [7:0] b);
        start = 1'b1;
        rx_valid = offer;
        rx_data = b;
        @(negedge clk);
        if (offer) check("start_byte_consumed", 32'(rx_valid && rx_ready), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic expDone, input logic expErr, input int expWrites);
        check({name, "_done"}, 32'(done), 32'(expDone));
        check({name, "_error"}, 32'(error), 32'(expErr));
        check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(!expDone));
        check({name, "_writes"}, 32'(weCount), 32'(expWrites));
    endtask

    initial begin
        bytes_t nominal, badSum, big, f;
        logic [7:0] x;
        nominal = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h0A, 8'h20, 8'h09, 8'h00, 8'h14, 8'h1F};
        badSum  = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h0A, 8'h20, 8'h09, 8'h00, 8'h14, 8'h00};

        reset = 1'b0;
        idleCycles(3);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        reset = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'hA5;
        idleCycles(3);
        rx_valid = 1'b0;

        weCount = 0;
        pulseStart(1'b0, 8'h00);
        applyStimulus(nominal, 0);
        checkOutput("nominal", 1'b1, 1'b0, 2);
        check("nominal_word0", ram[0], 32'h2008000A);
        check("nominal_word1", ram[1], 32'h20090014);

        weCount = 0;
        pulseStart(1'b0, 8'h00);
        applyStimulus(badSum, 0);
        idleCycles(100);
        checkOutput("badsum", 1'b0, 1'b1, 2);

        weCount = 0;
        ram[0] = 32'h0;
        pulseStart(1'b0, 8'h00);
        applyStimulus('{8'h00, 8'hFF, 8'h5A}, 0);
        applyStimulus(nominal, 2);
        checkOutput("resync", 1'b1, 1'b0, 2);
        check("resync_word0", ram[0], 32'h2008000A);

        weCount = 0;
        pulseStart(1'b0, 8'h00);
        applyStimulus('{8'hA5, 8'h20}, 0);
        checkOutput("len_0x20", 1'b0, 1'b1, 0);
        pulseStart(1'b0, 8'h00);
        applyStimulus('{8'hA5, 8'h00}, 0);
        checkOutput("len_0x00", 1'b0, 1'b1, 0);
        pulseStart(1'b0, 8'h00);
        applyStimulus('{8'hA5, 8'h11}, 0);
        checkOutput("len_0x11", 1'b0, 1'b1, 0);

        big = '{8'hA5, 8'h10};
        x = 8'h00;
        for (int i = 0; i < 64; i++) begin
            big.push_back(8'(i * 7 + 3));
            x = x ^ 8'(i * 7 + 3);
        end
        big.push_back(x);
        weCount = 0;
        pulseStart(1'b0, 8'h00);
        applyStimulus(big, 0);
        checkOutput("full_depth", 1'b1, 1'b0, 16);
        check("full_word0", ram[0], 32'h030A1118);
        check("full_word15", ram[15], 32'hA7AEB5BC);

        weCount = 0;
        pulseStart(1'b0, 8'h00);
        applyStimulus('{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h0A, 8'h20, 8'h09}, 0);
        pulseStart(1'b1, 8'hA5);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        applyStimulus('{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44}, 0);
        checkOutput("restart", 1'b1, 1'b0, 2);
        check("restart_word0", ram[0], 32'h11223344);

        pulseStart(1'b0, 8'h00);
        applyStimulus('{8'hA5, 8'h01, 8'h11, 8'h22}, 0);
        rx_valid = 1'b1;
        rx_data = 8'h33;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        idleCycles(3);
        reset = 1'b1;
        idleCycles(4);
        check("postrst_rx_ready", 32'(rx_ready), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);
        rx_valid = 1'b0;
        idleCycles(2);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
